spi_xfer_engine: RTL and testbench
==================================

SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, max shift length in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter PERI_CNT, default 4, number of peripheral chip selects.
REQ-003 SHALL have parameter CLK_DIV_W, default 8, width of the clock divider input.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- sync_rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  global enable; when low, all state freezes.
- start_txn  in  1  request a transaction.
- spi_mode  in  2  [0]=CPOL, [1]=CPHA; sampled at start.
- byte_sel  in  3  byte count minus one (N=byte_sel+1, 1..8, limited to DATA_WIDTH/8); sampled at start.
- clk_div  in  CLK_DIV_W  s_clk half-period = clk_div+1 enabled cycles; sampled at start.
- parallel_wr_data  in  DATA_WIDTH  TX data; bits [8N-1:0] sent; sampled at start.
- chip_sel_one_cold  in  PERI_CNT  target select, exactly one bit 0; sampled at start.
- poci  in  1  serial data from peripheral.
- copi  out  1  serial data to peripheral.
- s_clk  out  1  SPI clock.
- s_chip_sel_one_cold  out  PERI_CNT  chip selects, all 1 when idle.
- parallel_rd_data  out  DATA_WIDTH  received data, right-aligned, upper bits 0.
- busy  out  1  high in every non-IDLE state.
- end_txn  out  1  one-cycle pulse at completion.
- sel_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-005 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE; H = clk_div+1.
REQ-006 In IDLE with start_txn=1, valid select, and clk_en=1, it SHALL latch all "sampled at start" inputs and enter SETUP next cycle.
REQ-007 A start with chip_sel_one_cold not exactly one-cold SHALL be rejected: stay IDLE, pulse sel_err for one cycle.
REQ-008 start_txn while busy SHALL be ignored, with no error.
REQ-009 SETUP SHALL drive the latched select onto s_chip_sel_one_cold for H cycles; s_clk = CPOL.
REQ-010 SHIFT SHALL produce 2N*8... exactly 16N s_clk edges (8N full periods), each half-period H cycles.
REQ-011 Bit order SHALL be MSB first: the first bit sent is bit 8N-1; the first bit received is stored at bit 8N-1 of the result.
REQ-012 CPHA=0: first bit SHALL be on copi on entry to SETUP; sample poci on leading edges; shift on trailing edges.
REQ-013 CPHA=1: SHALL shift on leading edges and sample on trailing edges.
REQ-014 HOLD SHALL keep the select asserted with s_clk=CPOL for H cycles, then release all selects to 1.
REQ-015 DONE SHALL load parallel_rd_data and pulse end_txn for one cycle.
REQ-016 Start-to-end_txn latency SHALL be 1 + H*(8N*2+2) enabled cycles.
REQ-017 parallel_rd_data SHALL hold its value until the next DONE.
REQ-018 copi SHALL be 0 in IDLE.
REQ-019 clk_en low mid-transaction SHALL freeze all state and outputs, with no lost or duplicated edges.

Reset
REQ-020 Reset assertion SHALL take effect immediately, including mid-transaction, with these values: state=IDLE, copi=0, s_clk=0, s_chip_sel_one_cold all 1, parallel_rd_data=0, busy=0, end_txn=0, sel_err=0, counters=0.
REQ-021 After reset, s_clk SHALL take the latched CPOL only from SETUP onward.

Configuration
REQ-022 With macro SPI_LOOPBACK_EN defined, the module SHALL add input port loopback (1 bit); when loopback=1, the receiver takes copi internally instead of poci.
REQ-023 Without SPI_LOOPBACK_EN, the loopback port SHALL be absent and poci is always used.

Structure
REQ-024 Package spi_pkg SHALL hold the FSM state enum, the spi_mode field indices (CPOL_BIT, CPHA_BIT), and a byte-count-to-bit-count function.
REQ-025 A sub-module spi_clk_gen SHALL generate the half-period tick and the leading/trailing edge strobes from clk_div and CPOL.

Verification
REQ-026 Mode 0, N=1, clk_div=0, wr=0xA5, poci loops 0x3C: copi carries 10100101, rd_data=0x3C, end_txn exactly 19 cycles after start.
REQ-027 Mode 3, N=8, clk_div=3, wr=0x0123456789ABCDEF: 64 bits MSB first; s_clk idles high; rd matches the peripheral model.
REQ-028 chip_sel_one_cold=4'b1100 with start: sel_err pulses once, busy stays 0, selects stay 4'b1111.
REQ-029 Reset asserted mid-SHIFT: selects go to 4'b1111 and s_clk=0 at once; no end_txn; the next transaction is correct.
REQ-030 clk_en toggled 50% during an N=2 transfer: rd_data is identical to the run with clk_en held high; edge count is 32.
REQ-031 SPI_LOOPBACK_EN defined, loopback=1, wr=0xF00D, N=2: rd_data=0xF00D.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer engine.
package spi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StDone
   } spi_state_e;

   localparam int unsigned CPOL_BIT = 0;
   localparam int unsigned CPHA_BIT = 1;

   // Byte count (1..8) to bit count (8..64).
   function automatic logic [6:0] bytes_to_bits(input logic [3:0] nbytes);
      return {nbytes, 3'b000};
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer and s_clk generator; flags leading/trailing edges while shifting.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV_W = 8
) (
   input  logic                 clk,
   input  logic                 sync_rst_n,
   input  logic                 clk_en,
   input  logic                 load,
   input  logic                 cpol_in,
   input  logic                 active,
   input  logic                 shifting,
   input  logic [CLK_DIV_W-1:0] clk_div,
   output logic                 tick,
   output logic                 lead,
   output logic                 trail,
   output logic                 s_clk
);

   logic [CLK_DIV_W-1:0] cnt_q;
   logic                 s_clk_q;
   logic                 cpol_q;

   assign tick  = clk_en & active & (cnt_q == clk_div);
   // s_clk sits at CPOL before a leading edge and away from it before a trailing edge.
   assign lead  = tick & shifting & (s_clk_q == cpol_q);
   assign trail = tick & shifting & (s_clk_q != cpol_q);
   assign s_clk = s_clk_q;

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         cnt_q   <= '0;
         s_clk_q <= 1'b0;
         cpol_q  <= 1'b0;
      end else if (clk_en) begin
         if (load) begin
            cnt_q   <= '0;
            s_clk_q <= cpol_in;
            cpol_q  <= cpol_in;
         end else if (active) begin
            cnt_q <= tick ? '0 : cnt_q + CLK_DIV_W'(1);
            if (tick && shifting) begin
               s_clk_q <= ~s_clk_q;
            end
         end
      end
   end

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI controller: one MSB-first transfer of 1..8 bytes per start, modes 0-3.
// Define SPI_LOOPBACK_EN to add the loopback input (receiver takes copi instead of poci).
module spi_xfer_engine
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned PERI_CNT   = 4,
   parameter int unsigned CLK_DIV_W  = 8
) (
   input  logic                  clk,
   input  logic                  sync_rst_n,
   input  logic                  clk_en,
   input  logic                  start_txn,
   input  logic [1:0]            spi_mode,
   input  logic [2:0]            byte_sel,
   input  logic [CLK_DIV_W-1:0]  clk_div,
   input  logic [DATA_WIDTH-1:0] parallel_wr_data,
   input  logic [PERI_CNT-1:0]   chip_sel_one_cold,
   input  logic                  poci,
`ifdef SPI_LOOPBACK_EN
   input  logic                  loopback,
`endif
   output logic                  copi,
   output logic                  s_clk,
   output logic [PERI_CNT-1:0]   s_chip_sel_one_cold,
   output logic [DATA_WIDTH-1:0] parallel_rd_data,
   output logic                  busy,
   output logic                  end_txn,
   output logic                  sel_err
);

   localparam int unsigned MAX_BYTES = DATA_WIDTH / 8;
   localparam int unsigned EDGE_W    = $clog2(2 * DATA_WIDTH);

   spi_state_e            state_q;
   logic [DATA_WIDTH-1:0] tx_q;
   logic [DATA_WIDTH-1:0] rx_q;
   logic [DATA_WIDTH-1:0] rd_q;
   logic [PERI_CNT-1:0]   cs_q;
   logic [CLK_DIV_W-1:0]  div_q;
   logic [6:0]            nbits_q;
   logic [EDGE_W-1:0]     edge_q;
   logic                  cpha_q;
   logic                  copi_q;
   logic                  busy_q;
   logic                  end_q;
   logic                  err_q;

   logic [3:0]            nbytes_in;
   logic [6:0]            bits_in;
   logic [DATA_WIDTH-1:0] tx_init;
   logic                  sel_ok;
   logic                  start_ok;
   logic [7:0]            edge_total;
   logic [EDGE_W-1:0]     last_edge;
   logic                  rx_in;
   logic                  tick;
   logic                  lead;
   logic                  trail;
   logic                  sample;
   logic                  shift;
   logic                  active;
   logic                  shifting;

   always_comb begin
      nbytes_in = {1'b0, byte_sel} + 4'd1;
      if (nbytes_in > 4'(MAX_BYTES)) begin
         nbytes_in = 4'(MAX_BYTES);
      end
   end

   assign bits_in    = bytes_to_bits(nbytes_in);
   // Left-align the payload so the next bit out is always tx_q[MSB].
   assign tx_init    = parallel_wr_data << (7'(DATA_WIDTH) - bits_in);
   assign sel_ok     = $onehot(~chip_sel_one_cold);
   assign start_ok   = (state_q == StIdle) & start_txn & sel_ok;
   assign edge_total = {1'b0, nbits_q} << 1;
   assign last_edge  = EDGE_W'(edge_total - 8'd1);
   assign active     = (state_q == StSetup) | (state_q == StShift) | (state_q == StHold);
   assign shifting   = (state_q == StShift);
   assign sample     = cpha_q ? trail : lead;
   assign shift      = cpha_q ? lead : trail;

`ifdef SPI_LOOPBACK_EN
   assign rx_in = loopback ? copi_q : poci;
`else
   assign rx_in = poci;
`endif

   spi_clk_gen #(
      .CLK_DIV_W (CLK_DIV_W)
   ) u_clk_gen (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .clk_en     (clk_en),
      .load       (start_ok),
      .cpol_in    (spi_mode[CPOL_BIT]),
      .active     (active),
      .shifting   (shifting),
      .clk_div    (div_q),
      .tick       (tick),
      .lead       (lead),
      .trail      (trail),
      .s_clk      (s_clk)
   );

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         state_q <= StIdle;
         tx_q    <= '0;
         rx_q    <= '0;
         rd_q    <= '0;
         cs_q    <= '1;
         div_q   <= '0;
         nbits_q <= '0;
         edge_q  <= '0;
         cpha_q  <= 1'b0;
         copi_q  <= 1'b0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (clk_en) begin
         end_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q <= StSetup;
                  busy_q  <= 1'b1;
                  cs_q    <= chip_sel_one_cold;
                  div_q   <= clk_div;
                  nbits_q <= bits_in;
                  cpha_q  <= spi_mode[CPHA_BIT];
                  rx_q    <= '0;
                  edge_q  <= '0;
                  // CPHA=0 presents the first bit before the first edge.
                  if (spi_mode[CPHA_BIT]) begin
                     copi_q <= 1'b0;
                     tx_q   <= tx_init;
                  end else begin
                     copi_q <= tx_init[DATA_WIDTH-1];
                     tx_q   <= tx_init << 1;
                  end
               end else if (start_txn) begin
                  err_q <= 1'b1;
               end
            end
            StSetup: begin
               if (tick) begin
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (sample) begin
                  rx_q <= {rx_q[DATA_WIDTH-2:0], rx_in};
               end
               if (shift) begin
                  copi_q <= tx_q[DATA_WIDTH-1];
                  tx_q   <= tx_q << 1;
               end
               if (tick) begin
                  if (edge_q == last_edge) begin
                     state_q <= StHold;
                     edge_q  <= '0;
                  end else begin
                     edge_q <= edge_q + EDGE_W'(1);
                  end
               end
            end
            StHold: begin
               if (tick) begin
                  state_q <= StDone;
                  cs_q    <= '1;
                  copi_q  <= 1'b0;
                  rd_q    <= rx_q;
                  end_q   <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign copi                = copi_q;
   assign s_chip_sel_one_cold = cs_q;
   assign parallel_rd_data    = rd_q;
   assign busy                = busy_q;
   assign end_txn             = end_q;
   assign sel_err             = err_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Bench for spi_xfer_engine: vector table, SPI peripheral model and end-of-transfer scoreboard.
module tb_spi_xfer_engine;

   typedef struct {
      logic [1:0]  mode;
      logic [2:0]  bsel;
      logic [7:0]  div;
      logic [3:0]  sel;
      logic [63:0] wr;
      logic [63:0] pat;
      logic [63:0] exp_rd;
      logic [63:0] exp_tx;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [63:0] rd;
      logic [63:0] tx;
      int          edges;
      logic [3:0]  sel;
      int          lat;
      int          t_start;
   } exp_t;

   logic        clk = 1'b0;
   logic        sync_rst_n;
   logic        clk_en;
   logic        start_txn;
   logic [1:0]  spi_mode;
   logic [2:0]  byte_sel;
   logic [7:0]  clk_div;
   logic [63:0] parallel_wr_data;
   logic [3:0]  chip_sel_one_cold;
   logic        poci = 1'b0;
   logic        copi;
   logic        s_clk;
   logic [3:0]  s_chip_sel_one_cold;
   logic [63:0] parallel_rd_data;
   logic        busy;
   logic        end_txn;
   logic        sel_err;
`ifdef SPI_LOOPBACK_EN
   logic        loopback;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   sel_err_cnt = 0;
   logic end_prev = 1'b0;
   exp_t sb[$];

   // Peripheral model state
   logic        s_cpol = 1'b0;
   logic        s_cpha = 1'b0;
   int          s_nbits = 8;
   logic [63:0] s_pat = '0;
   logic        cs_active;
   logic        cs_prev = 1'b0;
   time         t_arm = 0;
   int          bptr = 0;
   logic [63:0] cap_tx = '0;
   int          edge_cnt = 0;
   logic [3:0]  cs_seen = '1;
   logic        lead_e;

   always #5 clk = ~clk;

   spi_xfer_engine dut (
      .clk                 (clk),
      .sync_rst_n          (sync_rst_n),
      .clk_en              (clk_en),
      .start_txn           (start_txn),
      .spi_mode            (spi_mode),
      .byte_sel            (byte_sel),
      .clk_div             (clk_div),
      .parallel_wr_data    (parallel_wr_data),
      .chip_sel_one_cold   (chip_sel_one_cold),
      .poci                (poci),
`ifdef SPI_LOOPBACK_EN
      .loopback            (loopback),
`endif
      .copi                (copi),
      .s_clk               (s_clk),
      .s_chip_sel_one_cold (s_chip_sel_one_cold),
      .parallel_rd_data    (parallel_rd_data),
      .busy                (busy),
      .end_txn             (end_txn),
      .sel_err             (sel_err)
   );

   assign cs_active = ~(&s_chip_sel_one_cold);

   // SPI peripheral: shifts s_pat out MSB first on poci, captures copi, counts s_clk edges.
   always @(s_clk or cs_active) begin
      if (cs_active && !cs_prev) begin
         t_arm    = $time;
         bptr     = s_nbits - 1;
         cap_tx   = '0;
         edge_cnt = 0;
         cs_seen  = s_chip_sel_one_cold;
         if (!s_cpha) begin
            poci = s_pat[bptr];
            bptr = bptr - 1;
         end
      end else if (cs_active && $time > t_arm) begin
         edge_cnt = edge_cnt + 1;
         lead_e   = (s_clk != s_cpol);
         if (lead_e != s_cpha) begin
            cap_tx = {cap_tx[62:0], copi};
         end else begin
            if (bptr >= 0) poci = s_pat[bptr];
            bptr = bptr - 1;
         end
      end
      cs_prev = cs_active;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic handle_end();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_end_txn: got 1 expected 0");
      end else begin
         e = sb.pop_front();
         chk("rd_data", parallel_rd_data, e.rd);
         chk("copi_bits", cap_tx, e.tx);
         chk("sclk_edges", 64'(edge_cnt), 64'(e.edges));
         chk("chip_sel", 64'(cs_seen), 64'(e.sel));
         if (e.lat != 0) chk("latency", 64'(cyc - e.t_start), 64'(e.lat));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (sel_err) sel_err_cnt++;
      if (end_txn && !end_prev) handle_end();
      end_prev = end_txn;
   endtask

   task automatic start_vec(input vec_t v, input bit push, input bit tog);
      exp_t e;
      spi_mode          = v.mode;
      byte_sel          = v.bsel;
      clk_div           = v.div;
      chip_sel_one_cold = v.sel;
      parallel_wr_data  = v.wr;
      s_cpol            = v.mode[0];
      s_cpha            = v.mode[1];
      s_nbits           = 8 * (int'(v.bsel) + 1);
      s_pat             = v.pat;
      if (push) begin
         e.rd      = v.exp_rd;
         e.tx      = v.exp_tx;
         e.edges   = 16 * (int'(v.bsel) + 1);
         e.sel     = v.sel;
         e.lat     = tog ? 0 : v.exp_lat;
         e.t_start = cyc;
         sb.push_back(e);
      end
      clk_en    = 1'b1;
      start_txn = 1'b1;
      step();
      start_txn = 1'b0;
   endtask

   task automatic wait_done(input bit tog, input logic cpol);
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         step();
         n++;
         if (tog) clk_en = ~clk_en;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no end_txn expected end_txn within 3000 cycles");
         sb.delete();
      end
      clk_en = 1'b1;
      step();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_sel", 64'(s_chip_sel_one_cold), 64'hF);
      chk("idle_copi", 64'(copi), 64'(0));
      chk("idle_sclk", 64'(s_clk), 64'(cpol));
      chk("idle_end", 64'(end_txn), 64'(0));
   endtask

   task automatic run_vec(input vec_t v, input bit tog);
      start_vec(v, 1'b1, tog);
      wait_done(tog, v.mode[0]);
   endtask

   initial begin
      vec_t vecs[5];
      vec_t rv;
      int   cnt0;
`ifdef SPI_LOOPBACK_EN
      vec_t lv;
`endif
      vecs[0] = '{mode: 2'd0, bsel: 3'd0, div: 8'd0, sel: 4'b1110, wr: 64'hA5,
                  pat: 64'h3C, exp_rd: 64'h3C, exp_tx: 64'hA5, exp_lat: 19};
      vecs[1] = '{mode: 2'd3, bsel: 3'd7, div: 8'd3, sel: 4'b0111, wr: 64'h0123456789ABCDEF,
                  pat: 64'hFEDCBA9876543210, exp_rd: 64'hFEDCBA9876543210,
                  exp_tx: 64'h0123456789ABCDEF, exp_lat: 521};
      vecs[2] = '{mode: 2'd1, bsel: 3'd1, div: 8'd1, sel: 4'b1101, wr: 64'hBEEF,
                  pat: 64'h99991234, exp_rd: 64'h1234, exp_tx: 64'hBEEF, exp_lat: 69};
      vecs[3] = '{mode: 2'd2, bsel: 3'd2, div: 8'd2, sel: 4'b1011, wr: 64'hC0FFEE,
                  pat: 64'h5A5A5A, exp_rd: 64'h5A5A5A, exp_tx: 64'hC0FFEE, exp_lat: 151};
      vecs[4] = '{mode: 2'd0, bsel: 3'd3, div: 8'd0, sel: 4'b1110, wr: 64'hFFFFFFFF12345678,
                  pat: 64'hAAAAAAAA87654321, exp_rd: 64'h87654321, exp_tx: 64'h12345678,
                  exp_lat: 67};

      sync_rst_n        = 1'b0;
      clk_en            = 1'b1;
      start_txn         = 1'b0;
      spi_mode          = '0;
      byte_sel          = '0;
      clk_div           = '0;
      parallel_wr_data  = '0;
      chip_sel_one_cold = '1;
`ifdef SPI_LOOPBACK_EN
      loopback          = 1'b0;
`endif
      repeat (3) step();
      chk("rst_sel", 64'(s_chip_sel_one_cold), 64'hF);
      chk("rst_sclk", 64'(s_clk), 64'(0));
      chk("rst_copi", 64'(copi), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rd", parallel_rd_data, 64'(0));
      chk("rst_err", 64'(sel_err), 64'(0));
      sync_rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], 1'b0);
      end

      // Rejected selects: two zeros, then no zero at all.
      cnt0 = sel_err_cnt;
      chip_sel_one_cold = 4'b1100;
      start_txn = 1'b1;
      step();
      start_txn = 1'b0;
      chk("sel_err_pulse", 64'(sel_err), 64'(1));
      chk("sel_err_busy", 64'(busy), 64'(0));
      chk("sel_err_sel", 64'(s_chip_sel_one_cold), 64'hF);
      repeat (3) step();
      chk("sel_err_count", 64'(sel_err_cnt - cnt0), 64'(1));
      chk("sel_err_busy_after", 64'(busy), 64'(0));
      cnt0 = sel_err_cnt;
      chip_sel_one_cold = 4'b1111;
      start_txn = 1'b1;
      step();
      start_txn = 1'b0;
      repeat (3) step();
      chk("sel_err_none_zero", 64'(sel_err_cnt - cnt0), 64'(1));

      // Starts while busy are ignored, bad select or not.
      cnt0 = sel_err_cnt;
      start_vec(vecs[0], 1'b1, 1'b0);
      repeat (4) step();
      chip_sel_one_cold = 4'b0000;
      start_txn = 1'b1;
      step();
      chip_sel_one_cold = 4'b1011;
      step();
      start_txn = 1'b0;
      wait_done(1'b0, 1'b0);
      chk("busy_start_no_err", 64'(sel_err_cnt - cnt0), 64'(0));

      // Reset in the middle of a mode-3 shift.
      rv     = vecs[1];
      rv.div = 8'd0;
      start_vec(rv, 1'b0, 1'b0);
      repeat (40) step();
      chk("pre_rst_busy", 64'(busy), 64'(1));
      #2 sync_rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", 64'(s_chip_sel_one_cold), 64'hF);
      chk("mid_rst_sclk", 64'(s_clk), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_copi", 64'(copi), 64'(0));
      chk("mid_rst_rd", parallel_rd_data, 64'(0));
      repeat (3) step();
      sync_rst_n = 1'b1;
      repeat (4) step();
      chk("post_rst_sclk", 64'(s_clk), 64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
      run_vec(vecs[2], 1'b0);

      // Same N=2 transfer with clk_en toggling every cycle.
      run_vec(vecs[2], 1'b1);

`ifdef SPI_LOOPBACK_EN
      lv = '{mode: 2'd0, bsel: 3'd1, div: 8'd0, sel: 4'b1110, wr: 64'hF00D,
             pat: 64'h0, exp_rd: 64'hF00D, exp_tx: 64'hF00D, exp_lat: 35};
      loopback = 1'b1;
      run_vec(lv, 1'b0);
      loopback = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
